// File: rtl/smp_timer_bank.sv
// smp_timer_bank: bank of NUM_TIMERS prescaled timers on the SMP local
// register bus. Each timer divides a slow or fast prescaler tick by an 8-bit
// period and counts periods in an OUT_W-bit counter that clears on read.
// Overflow of a counter raises a sticky flag; enabled flags drive IRQ.
//
// Bus semantics: WR and RD are single-cycle strobes qualified by ADDR. There
// is no backpressure; every strobe is accepted on the edge where it is high.
// RDATA is a pure function of ADDR and current register state. When WR and
// RD are high together both side effects are applied on the same edge.
module smp_timer_bank #(
  parameter int NUM_TIMERS = 3,
  parameter int OUT_W = 4,
  parameter int PRESCALE_SLOW = 128,
  parameter int PRESCALE_FAST = 16,
  parameter logic [NUM_TIMERS-1:0] FAST_MASK = 3'b100
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        ENABLE,
  input  logic [3:0]                  ADDR,
  input  logic                        WR,
  input  logic                        RD,
  input  logic [7:0]                  WDATA,
  output logic [7:0]                  RDATA,
  output logic                        IRQ,
  output logic [NUM_TIMERS*OUT_W-1:0] TOUT
);

  // Base counter spans one slow period; a degenerate prescaler of 1 still
  // needs a one-bit counter so the mask compare below stays well formed.
  localparam int BASE_W = (PRESCALE_SLOW > 1) ? $clog2(PRESCALE_SLOW) : 1;
  localparam logic [BASE_W-1:0] SLOW_LAST = BASE_W'(PRESCALE_SLOW - 1);
  localparam logic [BASE_W-1:0] FAST_LAST = BASE_W'(PRESCALE_FAST - 1);

  localparam logic [3:0] ADDR_CTRL     = 4'd0;
  localparam logic [3:0] ADDR_IRQ_EN   = 4'd1;
  localparam logic [3:0] ADDR_IRQ_STAT = 4'd2;

  // Architectural state
  logic [BASE_W-1:0]     base_q;
  logic [NUM_TIMERS-1:0] ctrl_q;
  logic [NUM_TIMERS-1:0] irq_en_q;
  logic [NUM_TIMERS-1:0] irq_stat_q;
  logic [7:0]            div_q [NUM_TIMERS];
  logic [7:0]            cnt_q [NUM_TIMERS];
  logic [OUT_W-1:0]      out_q [NUM_TIMERS];
  logic                  irq_q;

  // Decoded strobes and per-timer events
  logic                  slow_tick;
  logic                  fast_tick;
  logic                  wr_ctrl;
  logic                  wr_irq_en;
  logic                  wr_irq_stat;
  logic [NUM_TIMERS-1:0] wr_div;
  logic [NUM_TIMERS-1:0] rd_clr;
  logic [NUM_TIMERS-1:0] tick;
  logic [NUM_TIMERS-1:0] turn_on;
  logic [NUM_TIMERS-1:0] inc;
  logic [NUM_TIMERS-1:0] wrap;
  logic [NUM_TIMERS-1:0] stat_clr;
  logic [7:0]            cnt_d [NUM_TIMERS];
  logic [OUT_W-1:0]      out_d [NUM_TIMERS];

  // Prescaler ticks: slow fires once per full base wrap, fast whenever the
  // low bits of the base counter are all ones. Both are gated by ENABLE.
  always_comb begin : prescale
    slow_tick = ENABLE && ((base_q & SLOW_LAST) == SLOW_LAST);
    fast_tick = ENABLE && ((base_q & FAST_LAST) == FAST_LAST);
  end

  // Bus decode and per-timer event detection.
  always_comb begin : decode
    wr_ctrl     = WR && (ADDR == ADDR_CTRL);
    wr_irq_en   = WR && (ADDR == ADDR_IRQ_EN);
    wr_irq_stat = WR && (ADDR == ADDR_IRQ_STAT);
    stat_clr    = wr_irq_stat ? WDATA[NUM_TIMERS-1:0] : '0;
    wr_div      = '0;
    rd_clr      = '0;
    tick        = '0;
    turn_on     = '0;
    inc         = '0;
    wrap        = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      wr_div[i]  = WR && (ADDR == 4'(4 + i));
      rd_clr[i]  = RD && (ADDR == 4'(8 + i));
      tick[i]    = ctrl_q[i] && (FAST_MASK[i] ? fast_tick : slow_tick);
      // A 0->1 enable write restarts the timer; the stale enable bit is
      // still 0 this cycle so no tick can coincide with the restart.
      turn_on[i] = wr_ctrl && WDATA[i] && !ctrl_q[i];
      // 8-bit wrapping compare: DIV=0 means 256 ticks, DIV=1 means 1 tick.
      inc[i]     = tick[i] && ((cnt_q[i] + 8'd1) == div_q[i]);
      // A read-clear in the same cycle replaces the increment with a load
      // of 1, so the counter never passes through the all-ones->0 wrap.
      wrap[i]    = inc[i] && !rd_clr[i] && (&out_q[i]);
    end
  end

  // Next-state for stage and output counters. Restart beats read-clear,
  // read-clear keeps a coincident increment by loading 1 instead of 0.
  always_comb begin : timer_next
    for (int i = 0; i < NUM_TIMERS; i++) begin
      cnt_d[i] = cnt_q[i];
      out_d[i] = out_q[i];
      if (turn_on[i]) begin
        cnt_d[i] = 8'd0;
        out_d[i] = '0;
      end else begin
        if (tick[i]) begin
          cnt_d[i] = inc[i] ? 8'd0 : (cnt_q[i] + 8'd1);
        end
        if (rd_clr[i]) begin
          out_d[i] = inc[i] ? OUT_W'(1) : '0;
        end else if (inc[i]) begin
          out_d[i] = out_q[i] + OUT_W'(1);
        end
      end
    end
  end

  // Free-running base counter, advancing only on enabled cycles.
  always_ff @(posedge CLK) begin : base_reg
    if (!RST_N) begin
      base_q <= '0;
    end else if (ENABLE) begin
      base_q <= base_q + BASE_W'(1);
    end
  end

  // Control, mask and divider registers written from the bus; these take
  // writes regardless of ENABLE.
  always_ff @(posedge CLK) begin : cfg_reg
    if (!RST_N) begin
      ctrl_q   <= '0;
      irq_en_q <= '0;
      for (int i = 0; i < NUM_TIMERS; i++) begin
        div_q[i] <= 8'hFF;
      end
    end else begin
      if (wr_ctrl) begin
        ctrl_q <= WDATA[NUM_TIMERS-1:0];
      end
      if (wr_irq_en) begin
        irq_en_q <= WDATA[NUM_TIMERS-1:0];
      end
      for (int i = 0; i < NUM_TIMERS; i++) begin
        if (wr_div[i]) begin
          div_q[i] <= WDATA;
        end
      end
    end
  end

  // Stage and output counters.
  always_ff @(posedge CLK) begin : timer_reg
    if (!RST_N) begin
      for (int i = 0; i < NUM_TIMERS; i++) begin
        cnt_q[i] <= 8'd0;
        out_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_TIMERS; i++) begin
        cnt_q[i] <= cnt_d[i];
        out_q[i] <= out_d[i];
      end
    end
  end

  // Sticky overflow flags: write-1-clear, with a same-cycle set winning.
  always_ff @(posedge CLK) begin : stat_reg
    if (!RST_N) begin
      irq_stat_q <= '0;
    end else begin
      irq_stat_q <= (irq_stat_q & ~stat_clr) | wrap;
    end
  end

  // Interrupt line, registered one cycle behind the flags and mask.
  always_ff @(posedge CLK) begin : irq_reg
    if (!RST_N) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |(irq_stat_q & irq_en_q);
    end
  end

  // Read mux; unmapped addresses and unused upper bits read as zero.
  always_comb begin : read_mux
    RDATA = 8'd0;
    case (ADDR)
      ADDR_CTRL:     RDATA[NUM_TIMERS-1:0] = ctrl_q;
      ADDR_IRQ_EN:   RDATA[NUM_TIMERS-1:0] = irq_en_q;
      ADDR_IRQ_STAT: RDATA[NUM_TIMERS-1:0] = irq_stat_q;
      default: begin
        for (int i = 0; i < NUM_TIMERS; i++) begin
          if (ADDR == 4'(4 + i)) begin
            RDATA = div_q[i];
          end
          if (ADDR == 4'(8 + i)) begin
            RDATA[OUT_W-1:0] = out_q[i];
          end
        end
      end
    endcase
  end

  assign IRQ = irq_q;

  for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_tout
    assign TOUT[g*OUT_W +: OUT_W] = out_q[g];
  end

endmodule

// File: tb/tb_smp_timer_bank.sv
// Bench for smp_timer_bank: directed scenarios followed by a random phase,
// all checked every cycle against a behavioural model of the timer rules.
module tb_smp_timer_bank;

  localparam int NT   = 3;
  localparam int OW   = 4;
  localparam int PS   = 128;
  localparam int PF   = 16;
  localparam int OMAX = 1 << OW;
  localparam logic [NT-1:0] FM = 3'b100;
  localparam int TMASK = (1 << NT) - 1;

  logic             CLK;
  logic             RST_N;
  logic             ENABLE;
  logic [3:0]       ADDR;
  logic             WR;
  logic             RD;
  logic [7:0]       WDATA;
  logic [7:0]       RDATA;
  logic             IRQ;
  logic [NT*OW-1:0] TOUT;

  smp_timer_bank #(
    .NUM_TIMERS(NT), .OUT_W(OW), .PRESCALE_SLOW(PS),
    .PRESCALE_FAST(PF), .FAST_MASK(FM)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .ADDR(ADDR), .WR(WR),
    .RD(RD), .WDATA(WDATA), .RDATA(RDATA), .IRQ(IRQ), .TOUT(TOUT)
  );

  // Clock and reset block
  initial CLK = 1'b0;
  always #50 CLK = ~CLK;

  // Scoreboard state
  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];

  // Behavioural model, in plain integers
  int m_base;
  int m_ctrl;
  int m_en;
  int m_stat;
  int m_div [NT];
  int m_cnt [NT];
  int m_out [NT];
  bit m_irq;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_base = 0; m_ctrl = 0; m_en = 0; m_stat = 0; m_irq = 1'b0;
    for (int i = 0; i < NT; i++) begin
      m_div[i] = 255; m_cnt[i] = 0; m_out[i] = 0;
    end
  endtask

  function automatic bit m_tick(input int i);
    bit on_i;
    on_i = ((m_ctrl >> i) & 1) == 1;
    if (FM[i]) return ENABLE && on_i && ((m_base % PF) == PF - 1);
    return ENABLE && on_i && ((m_base % PS) == PS - 1);
  endfunction

  function automatic bit m_inc(input int i);
    return m_tick(i) && (((m_cnt[i] + 1) % 256) == m_div[i]);
  endfunction

  function automatic int m_read(input int a);
    if (a == 0) return m_ctrl;
    if (a == 1) return m_en;
    if (a == 2) return m_stat;
    if (a >= 4 && a < 4 + NT) return m_div[a - 4];
    if (a >= 8 && a < 8 + NT) return m_out[a - 8];
    return 0;
  endfunction

  function automatic logic [NT*OW-1:0] m_tout();
    logic [NT*OW-1:0] v;
    v = '0;
    for (int i = 0; i < NT; i++) v[i*OW +: OW] = OW'(m_out[i]);
    return v;
  endfunction

  // Advance the model by one clock edge using the inputs now applied.
  task automatic model_edge();
    int n_cnt [NT];
    int n_out [NT];
    int set_bits, clr, a, wd;
    bit on_edge, rd_i, inc_i, n_irq;
    if (!RST_N) begin
      m_reset();
      return;
    end
    a = int'(ADDR);
    wd = int'(WDATA);
    set_bits = 0;
    for (int i = 0; i < NT; i++) begin
      on_edge = WR && a == 0 && ((wd >> i) & 1) == 1 && ((m_ctrl >> i) & 1) == 0;
      rd_i = RD && a == 8 + i;
      inc_i = m_inc(i);
      n_cnt[i] = m_cnt[i];
      n_out[i] = m_out[i];
      if (on_edge) begin
        n_cnt[i] = 0;
        n_out[i] = 0;
      end else begin
        if (m_tick(i)) n_cnt[i] = inc_i ? 0 : (m_cnt[i] + 1) % 256;
        if (rd_i) n_out[i] = inc_i ? 1 : 0;
        else if (inc_i) begin
          n_out[i] = (m_out[i] + 1) % OMAX;
          if (n_out[i] == 0) set_bits |= 1 << i;
        end
      end
    end
    n_irq = (m_stat & m_en) != 0;
    clr = (WR && a == 2) ? (wd & TMASK) : 0;
    m_stat = (m_stat & ~clr) | set_bits;
    if (WR && a == 0) m_ctrl = wd & TMASK;
    if (WR && a == 1) m_en = wd & TMASK;
    if (WR && a >= 4 && a < 4 + NT) m_div[a - 4] = wd;
    for (int i = 0; i < NT; i++) begin
      m_cnt[i] = n_cnt[i];
      m_out[i] = n_out[i];
    end
    m_irq = n_irq;
    if (ENABLE) m_base = (m_base + 1) % PS;
  endtask

  task automatic check_all();
    chk("tout", 32'(TOUT), 32'(m_tout()));
    chk("irq", 32'(IRQ), 32'(m_irq));
    chk("rdata", 32'(RDATA), 32'(m_read(int'(ADDR))));
  endtask

  // Driver tasks
  task automatic step();
    model_edge();
    @(posedge CLK);
    #1;
    WR = 1'b0;
    RD = 1'b0;
    check_all();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wr(input int a, input int d);
    ADDR = 4'(a); WDATA = 8'(d); WR = 1'b1;
    step();
  endtask

  task automatic rd_clear(input int a, input string tag);
    ADDR = 4'(a); RD = 1'b1;
    exp_q.push_back(8'(m_read(a)));
    #1;
    chk(tag, 32'(RDATA), 32'(exp_q.pop_front()));
    step();
  endtask

  task automatic peek(input int a, input string tag, input int exp);
    ADDR = 4'(a);
    #1;
    chk(tag, 32'(RDATA), 32'(exp));
  endtask

  logic [NT*OW-1:0] snap;
  int n;
  bit found;

  initial begin
    RST_N = 1'b0; ENABLE = 1'b1; ADDR = 4'd0; WR = 1'b0; RD = 1'b0; WDATA = 8'd0;
    m_reset();
    step();
    step();
    RST_N = 1'b1;

    // Reset values on every address
    for (int a = 0; a < 16; a++) begin
      peek(a, "rst_map", (a >= 4 && a < 4 + NT) ? 255 : 0);
    end
    chk("rst_irq", 32'(IRQ), 32'd0);
    chk("rst_tout", 32'(TOUT), 32'd0);

    // T0 slow, DIV0=2: one increment per 256 cycles
    wr(4, 2);
    wr(0, 1);
    run(256);
    peek(8, "t1_out0_256", 1);
    run(256);
    peek(8, "t1_out0_512", 2);

    // T2 fast, DIV2=1: wraps after 16 increments and raises IRQ
    wr(6, 1);
    wr(1, 4);
    wr(0, 5);
    run(256);
    peek(10, "t2_out2_wrap", 0);
    ADDR = 4'd2; #1;
    chk("t2_stat2", 32'((RDATA >> 2) & 8'd1), 32'd1);
    step();
    chk("t2_irq", 32'(IRQ), 32'd1);

    // Read-clear in the exact cycle of a T0 increment keeps that increment
    found = 1'b0;
    for (int k = 0; k < 600 && !found; k++) begin
      if (m_inc(0)) found = 1'b1;
      else step();
    end
    chk("t3_wait_inc", 32'(found), 32'd1);
    rd_clear(8, "t3_old_val");
    chk("t3_out0_one", 32'(TOUT[OW-1:0]), 32'd1);
    while (m_inc(0)) step();
    rd_clear(8, "t3_plain_val");
    chk("t3_out0_zero", 32'(TOUT[OW-1:0]), 32'd0);

    // T1 DIV1=0: disable/re-enable restarts, full period of 256*128 cycles
    wr(5, 0);
    wr(0, 7);
    run(1000);
    wr(0, 5);
    snap = TOUT;
    run(300);
    chk("t4_frozen", 32'(TOUT[2*OW-1:OW]), 32'(snap[2*OW-1:OW]));
    wr(0, 7);
    chk("t4_restart", 32'(TOUT[2*OW-1:OW]), 32'd0);
    n = 0;
    while (TOUT[2*OW-1:OW] == '0 && n < 33000) begin
      step();
      n++;
    end
    chk("t4_period", 32'(n >= 255 * PS + 1 && n <= 256 * PS), 32'd1);

    // Clear write colliding with a T2 overflow: the set wins
    found = 1'b0;
    for (int k = 0; k < 600 && !found; k++) begin
      if (m_inc(2) && m_out[2] == OMAX - 1) found = 1'b1;
      else step();
    end
    chk("t5_wait_wrap", 32'(found), 32'd1);
    wr(2, 4);
    peek(2, "t5_set_wins", int'(m_read(2)));
    chk("t5_bit2_kept", 32'((RDATA >> 2) & 8'd1), 32'd1);
    while (m_inc(2) && m_out[2] == OMAX - 1) step();
    wr(2, 4);
    ADDR = 4'd2; #1;
    chk("t5_cleared", 32'((RDATA >> 2) & 8'd1), 32'd0);
    chk("t5_irq_lag", 32'(IRQ), 32'd1);
    step();
    chk("t5_irq_drop", 32'(IRQ), 32'd0);

    // ENABLE=0: everything frozen, DIV writes still land
    ENABLE = 1'b0;
    snap = TOUT;
    for (int k = 0; k < 1000; k++) begin
      if ($urandom_range(0, 7) == 0) wr(4 + $urandom_range(0, NT - 1), $urandom_range(1, 255));
      else step();
    end
    chk("t6_frozen", 32'(TOUT), 32'(snap));
    for (int i = 0; i < NT; i++) peek(4 + i, "t6_div", m_div[i]);
    ENABLE = 1'b1;

    // Random bus traffic, ENABLE toggling, simultaneous WR/RD
    for (int k = 0; k < 3000; k++) begin
      ENABLE = ($urandom_range(0, 3) != 0);
      ADDR = 4'($urandom_range(0, 15));
      WDATA = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 7))
        0: WR = 1'b1;
        1: begin ADDR = 4'($urandom_range(8, 8 + NT - 1)); RD = 1'b1; end
        2: begin WR = 1'b1; RD = 1'b1; end
        3: begin ADDR = 4'($urandom_range(4, 4 + NT - 1)); WDATA = 8'($urandom_range(0, 3)); WR = 1'b1; end
        default: ;
      endcase
      #1;
      chk("rand_rdata", 32'(RDATA), 32'(m_read(int'(ADDR))));
      step();
    end

    // Reset mid-count returns everything to reset values
    ENABLE = 1'b1;
    wr(0, 7);
    run(200);
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    for (int a = 0; a < 16; a++) begin
      peek(a, "rst2_map", (a >= 4 && a < 4 + NT) ? 255 : 0);
    end
    chk("rst2_tout", 32'(TOUT), 32'd0);
    chk("rst2_irq", 32'(IRQ), 32'd0);
    ADDR = 4'd0;
    run(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
